wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between the in-order pipeline writeback stage and the long-latency multiply/divide unit (MDU).
- Pipeline writes always win. MDU results are buffered in a small FIFO and drained into idle write slots.
- Drives a stall request when a buffered MDU result has waited too long.
- Sits between stage_writeback and the register file. It adds one registered cycle on the write port.

Parameters:
- DEPTH, 2, number of MDU result FIFO entries (power of two, >=2)
- STARVE_LIMIT, 4, head-of-FIFO wait cycles before stall_req asserts (>=1)

Ports:
- clk  input  1  core clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- pipe_wr_enable  input  1  pipeline writeback wants to write this cycle
- pipe_rd  input  5  pipeline destination register
- pipe_write_data  input  32  pipeline write data
- mdu_valid  input  1  MDU result valid
- mdu_ready  output  1  arbiter accepts the MDU result this cycle
- mdu_rd  input  5  MDU destination register
- mdu_data  input  32  MDU result
- rf_wr_enable  output  1  register-file write enable (registered)
- rf_rd  output  5  register-file write address (registered)
- rf_write_data  output  32  register-file write data (registered)
- stall_req  output  1  request to the pipeline controller to insert a writeback bubble
- pending_count  output  $clog2(DEPTH)+1  number of valid FIFO entries

Behaviour:
- Reset, asynchronous, while rst=1:
  - rf_wr_enable=0, rf_rd=0, rf_write_data=0.
  - FIFO empty, all valid bits 0, pointers 0.
  - Age counter 0, stall_req=0, mdu_ready=0, pending_count=0.
- After reset deasserts: mdu_ready = (pending_count != DEPTH). It is combinational from registered count and does not depend on a same-cycle pop.
- MDU handshake:
  - A transfer occurs when mdu_valid & mdu_ready.
  - The MDU holds rd and data stable while valid and not ready.
- x0 rule:
  - pipe_wr_enable with pipe_rd=0 is treated as no request.
  - An MDU transfer with mdu_rd=0 is accepted and discarded, never written.
- Per-cycle slot selection, in priority order; the chosen write appears on rf_* at the next edge (latency 1):
  1. pipe_wr_enable & pipe_rd!=0: write the pipeline value.
  2. Else, a valid FIFO head exists: write the head and pop it.
  3. Else, FIFO empty and an MDU transfer with rd!=0 occurs: bypass it straight to rf_* without enqueuing.
  4. Else: rf_wr_enable=0, and rf_rd/rf_write_data hold their previous values.
- Enqueue: an MDU transfer (rd!=0) that is not bypassed is written at the tail.
  - Simultaneous pop and enqueue in one cycle is allowed.
  - Enqueue is permitted only when not full, even if a pop occurs that cycle.
- WAW kill:
  - When a pipeline write wins (rule 1), every FIFO entry with rd==pipe_rd is invalidated in the same edge.
  - An MDU transfer in the same cycle with mdu_rd==pipe_rd is accepted and dropped.
  - Invalidated entries still occupy slots and count in pending_count.
  - When an invalidated entry reaches the head, it is popped in the next slot as if it were written, but with rf_wr_enable=0. This consumes the slot.
- Age counter (saturating at STARVE_LIMIT):
  - Increments each cycle a valid FIFO head exists and is not popped.
  - Clears on pop and whenever the FIFO is empty.
  - stall_req = (age >= STARVE_LIMIT), combinational from the registered age.
  - The controller responds by deasserting pipe_wr_enable; the head then drains via rule 2.
- pending_count is updated each edge as count + enqueue - pop and is never above DEPTH.

Test Plan:
- Reset mid-operation: fill the FIFO with 2 entries, assert rst asynchronously -> rf_wr_enable=0, pending_count=0 and mdu_ready=0 immediately; mdu_ready=1 on the first cycle after release.
- Bypass: idle pipeline, mdu_valid, rd=5, data=0x0000_00AA -> next cycle rf_wr_enable=1, rf_rd=5, rf_write_data=0xAA; pending_count stays 0.
- Conflict: same cycle pipe rd=3/0x11 and mdu rd=7/0x22; following cycle pipe idle -> cycle+1 writes x3=0x11, cycle+2 writes x7=0x22; pending_count goes 1 then 0.
- Full/backpressure: DEPTH=2, continuous pipe writes, 3 MDU results offered -> first two accepted, mdu_ready=0 on the third; pending_count=2; after STARVE_LIMIT=4 blocked cycles stall_req=1; on the first bubble the head drains and stall_req clears.
- WAW kill: FIFO holds rd=9/0x55, then pipe writes rd=9/0x66 -> x9 written 0x66; the later head pop produces rf_wr_enable=0; x9 final value 0x66.
- x0: pipe rd=0 and mdu rd=0 offered -> no rf write; mdu_ready=1 and the transfer completes; pending_count stays 0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the single register-file write port between the pipeline
//   writeback stage and the multiply/divide unit (MDU). Pipeline writes
//   always win. MDU results are parked in a small FIFO and drained into idle
//   slots. The write port is registered, so a selected write lands on o_rf_*
//   one cycle after selection.
//
// Ports
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_pipe_*               pipeline writeback request (rd, data, enable)
//   i_mdu_valid/o_mdu_ready MDU result handshake, with i_mdu_rd/i_mdu_data
//   o_rf_*                 registered register-file write port
//   o_stall_req            asks the controller for a writeback bubble
//   o_pending_count        occupied FIFO slots, including killed entries
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_pipe_wr_enable,
  input  logic [4:0]               i_pipe_rd,
  input  logic [31:0]              i_pipe_write_data,
  input  logic                     i_mdu_valid,
  output logic                     o_mdu_ready,
  input  logic [4:0]               i_mdu_rd,
  input  logic [31:0]              i_mdu_data,
  output logic                     o_rf_wr_enable,
  output logic [4:0]               o_rf_rd,
  output logic [31:0]              o_rf_write_data,
  output logic                     o_stall_req,
  output logic [$clog2(DEPTH):0]   o_pending_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int AGW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);
  localparam logic [AGW-1:0] LIM  = AGW'(STARVE_LIMIT);

  typedef struct packed {
    logic        vld;   // cleared by a WAW kill; slot stays occupied
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t            r_fifo [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count;
  logic [AGW-1:0]  r_age;
  logic            r_rf_en;
  logic [4:0]      r_rf_rd;
  logic [31:0]     r_rf_data;

  logic            w_pipe_win, w_xfer, w_empty, w_pop, w_bypass, w_enq;
  ent_t            w_head;
  logic [CW-1:0]   w_count_nxt;
  logic [AGW-1:0]  w_age_nxt;

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign o_mdu_ready = !i_rst && (r_count != FULL);

  assign w_pipe_win = i_pipe_wr_enable && (i_pipe_rd != 5'd0);
  assign w_xfer     = i_mdu_valid && o_mdu_ready;
  assign w_empty    = (r_count == '0);
  assign w_head     = r_fifo[r_rptr];
  // Killed heads are popped too; they just don't raise the write enable.
  assign w_pop      = !w_pipe_win && !w_empty;
  assign w_bypass   = !w_pipe_win && w_empty && w_xfer && (i_mdu_rd != 5'd0);
  // x0 results and results made stale by a same-cycle pipeline write to the
  // same register are accepted but never stored.
  assign w_enq      = w_xfer && (i_mdu_rd != 5'd0) && !w_bypass &&
                      !(w_pipe_win && (i_mdu_rd == i_pipe_rd));

  always_comb begin
    w_count_nxt = r_count;
    if (w_enq && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_enq && w_pop) w_count_nxt = r_count - CW'(1);
  end

  always_comb begin
    w_age_nxt = r_age;
    if (w_empty || w_pop)  w_age_nxt = '0;
    else if (r_age != LIM) w_age_nxt = r_age + AGW'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_age     <= '0;
      r_rf_en   <= 1'b0;
      r_rf_rd   <= '0;
      r_rf_data <= '0;
    end else begin
      // Write-port slot selection.
      r_rf_en <= 1'b0;
      if (w_pipe_win) begin
        r_rf_en   <= 1'b1;
        r_rf_rd   <= i_pipe_rd;
        r_rf_data <= i_pipe_write_data;
      end else if (w_pop) begin
        r_rf_en <= w_head.vld;
        if (w_head.vld) begin
          r_rf_rd   <= w_head.rd;
          r_rf_data <= w_head.data;
        end
      end else if (w_bypass) begin
        r_rf_en   <= 1'b1;
        r_rf_rd   <= i_mdu_rd;
        r_rf_data <= i_mdu_data;
      end

      // WAW kill: buffered results older than the winning pipeline write.
      if (w_pipe_win) begin
        for (int i = 0; i < DEPTH; i++)
          if (r_fifo[i].rd == i_pipe_rd) r_fifo[i].vld <= 1'b0;
      end

      // Enqueue needs a free slot, so the tail never aliases the head.
      if (w_enq) begin
        r_fifo[r_wptr] <= '{vld: 1'b1, rd: i_mdu_rd, data: i_mdu_data};
        r_wptr         <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);

      r_count <= w_count_nxt;
      r_age   <= w_age_nxt;
    end
  end

  assign o_stall_req     = (r_age >= LIM);
  assign o_rf_wr_enable  = r_rf_en;
  assign o_rf_rd         = r_rf_rd;
  assign o_rf_write_data = r_rf_data;
  assign o_pending_count = r_count;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic        clk, rst;
  logic        pipe_we, mdu_valid, mdu_ready;
  logic [4:0]  pipe_rd, mdu_rd, rf_rd;
  logic [31:0] pipe_data, mdu_data, rf_data;
  logic        rf_en, stall;
  logic [1:0]  pend;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_pipe_wr_enable(pipe_we), .i_pipe_rd(pipe_rd), .i_pipe_write_data(pipe_data),
    .i_mdu_valid(mdu_valid), .o_mdu_ready(mdu_ready),
    .i_mdu_rd(mdu_rd), .i_mdu_data(mdu_data),
    .o_rf_wr_enable(rf_en), .o_rf_rd(rf_rd), .o_rf_write_data(rf_data),
    .o_stall_req(stall), .o_pending_count(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a queue of buffered results plus the last write.
  typedef struct { logic [4:0] rd; logic [31:0] d; bit v; } ent_t;
  ent_t        q[$];
  int          m_age;
  bit          m_en, m_known;
  logic [4:0]  m_rd;
  logic [31:0] m_dat;

  int total = 0, bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_age = 0; m_en = 0; m_known = 1; m_rd = '0; m_dat = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rf_wr_enable", rf_en, m_en);
      if (m_known) begin
        chk("rf_rd", rf_rd, m_rd);
        chk("rf_write_data", rf_data, m_dat);
      end
      chk("pending_count", pend, q.size());
      chk("stall_req", stall, m_age >= LIM);
      chk("mdu_ready", mdu_ready, q.size() != DEPTH);
    end
  end

  // One cycle: drive inputs, let the edge happen, advance the model, return
  // at the following falling edge.
  task automatic step(input bit pe, input logic [4:0] prd, input logic [31:0] pd,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    bit pw, xfer, pop, byp, enq;
    ent_t h;
    pipe_we = pe; pipe_rd = prd; pipe_data = pd;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    @(posedge clk);
    pw   = pe && (prd != 0);
    xfer = mv && (q.size() != DEPTH);
    pop = 0; byp = 0; m_en = 0;
    if (pw) begin
      m_en = 1; m_rd = prd; m_dat = pd; m_known = 1;
      foreach (q[i]) if (q[i].rd == prd) q[i].v = 0;
    end else if (q.size() != 0) begin
      pop = 1; h = q[0]; m_en = h.v;
      if (h.v) begin m_rd = h.rd; m_dat = h.d; m_known = 1; end
      else m_known = 0;
    end else if (xfer && mrd != 0) begin
      byp = 1; m_en = 1; m_rd = mrd; m_dat = md; m_known = 1;
    end
    enq = xfer && (mrd != 0) && !byp && !(pw && mrd == prd);
    if (q.size() == 0 || pop) m_age = 0;
    else if (m_age < LIM) m_age++;
    if (pop) void'(q.pop_front());
    if (enq) q.push_back('{mrd, md, 1'b1});
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit hv, acc;
    logic [4:0] hrd;
    logic [31:0] hdat;
    bit pe;

    rst = 1; pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_en", rf_en, 0);
    chk("rst_rd", rf_rd, 0);
    chk("rst_data", rf_data, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ready", mdu_ready, 0);
    chk("rst_stall", stall, 0);
    rst = 0;
    #1 chk("ready_after_rst", mdu_ready, 1);
    chk_en = 1;

    // Bypass into an empty FIFO.
    step(0, 0, 0, 1, 5, 32'hAA);
    chk("byp_en", rf_en, 1);
    chk("byp_rd", rf_rd, 5);
    chk("byp_data", rf_data, 32'hAA);
    chk("byp_pend", pend, 0);

    // Conflict: pipeline wins, MDU result buffered then drained.
    step(1, 3, 32'h11, 1, 7, 32'h22);
    chk("cf_rd1", rf_rd, 3);
    chk("cf_data1", rf_data, 32'h11);
    chk("cf_pend1", pend, 1);
    idle();
    chk("cf_en2", rf_en, 1);
    chk("cf_rd2", rf_rd, 7);
    chk("cf_data2", rf_data, 32'h22);
    chk("cf_pend2", pend, 0);

    // Full / backpressure / starvation.
    step(1, 1, 32'h100, 1, 10, 32'hA0);
    step(1, 1, 32'h101, 1, 11, 32'hB0);
    chk("full_pend", pend, 2);
    chk("full_ready", mdu_ready, 0);
    step(1, 1, 32'h102, 1, 12, 32'hC0);
    step(1, 1, 32'h103, 1, 12, 32'hC0);
    chk("starve_pre", stall, 0);
    step(1, 1, 32'h104, 1, 12, 32'hC0);
    chk("starve_stall", stall, 1);
    chk("starve_pend", pend, 2);
    step(0, 0, 0, 1, 12, 32'hC0);
    chk("drain_rd", rf_rd, 10);
    chk("drain_data", rf_data, 32'hA0);
    chk("drain_stall", stall, 0);
    chk("drain_pend", pend, 1);
    step(0, 0, 0, 1, 12, 32'hC0);
    chk("drain2_rd", rf_rd, 11);
    chk("drain2_pend", pend, 1);
    idle();
    chk("drain3_rd", rf_rd, 12);
    chk("drain3_pend", pend, 0);

    // WAW kill.
    step(1, 2, 32'h1, 1, 9, 32'h55);
    step(1, 9, 32'h66, 0, 0, 0);
    chk("waw_rd", rf_rd, 9);
    chk("waw_data", rf_data, 32'h66);
    chk("waw_pend", pend, 1);
    idle();
    chk("waw_kill_en", rf_en, 0);
    chk("waw_kill_pend", pend, 0);

    // x0 on both sources.
    chk("x0_ready", mdu_ready, 1);
    step(1, 0, 32'h77, 1, 0, 32'h88);
    chk("x0_en", rf_en, 0);
    chk("x0_pend", pend, 0);

    // Asynchronous reset mid-operation.
    step(1, 1, 32'h5, 1, 20, 32'h20);
    step(1, 1, 32'h6, 1, 21, 32'h21);
    chk("mid_pend_pre", pend, 2);
    pipe_we = 0; mdu_valid = 0;
    chk_en = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst_en", rf_en, 0);
    chk("mid_rst_pend", pend, 0);
    chk("mid_rst_ready", mdu_ready, 0);
    model_reset();
    @(posedge clk); @(negedge clk);
    rst = 0;
    #1 chk("mid_rel_ready", mdu_ready, 1);
    chk_en = 1;

    // Randomized traffic; MDU holds its result until accepted.
    hv = 0; hrd = 0; hdat = 0;
    for (int n = 0; n < 3000; n++) begin
      if (m_age >= LIM) pe = ($urandom_range(0, 3) == 0);
      else              pe = $urandom_range(0, 1);
      acc = hv && (q.size() != DEPTH);
      step(pe, 5'($urandom_range(0, 7)), $urandom, hv, hrd, hdat);
      if (acc || !hv) begin
        hv = ($urandom_range(0, 2) != 0);
        hrd = 5'($urandom_range(0, 7));
        hdat = $urandom;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
